// File: rtl/mmio_uart_pkg.sv
// Register map, STATUS/CTRL field positions and transmitter states for mmio_uart_tx.
package mmio_uart_pkg;

  localparam logic [63:0] ADDR_TXDATA = 64'h0000_0000_FFFF_0080;
  localparam logic [63:0] ADDR_STATUS = 64'h0000_0000_FFFF_0088;
  localparam logic [63:0] ADDR_CTRL   = 64'h0000_0000_FFFF_0090;

  localparam int unsigned ST_EMPTY_BIT   = 0;
  localparam int unsigned ST_FULL_BIT    = 1;
  localparam int unsigned ST_BUSY_BIT    = 2;
  localparam int unsigned ST_OVERRUN_BIT = 3;
  localparam int unsigned ST_COUNT_LSB   = 8;
  localparam int unsigned ST_COUNT_MSB   = 14;

  localparam int unsigned CTRL_DIV_LSB   = 0;
  localparam int unsigned CTRL_DIV_MSB   = 15;
  localparam int unsigned CTRL_IRQEN_BIT = 16;

  // Explicit encodings keep the legacy state numbering.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted only with a same-cycle pop.
module sync_fifo
  import mmio_uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL registers, byte FIFO, 8N1 serializer.
// Optional even-parity bit after the data bits when MMIO_UART_TX_PARITY_EN is defined.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] data,
  input  logic [63:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] rd_data,
  output logic        UartAddress,
  output logic        UartInterrupt,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit_tx, w_hit_status, w_hit_ctrl;
  logic          w_push, w_ctrl_wr, w_pop, w_overrun_evt;
  logic          w_full, w_empty, w_busy, w_bit_end, w_tx_next;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [15:0]   w_reload;
  logic          w_unused_data;

  logic [15:0]   r_divisor;
  logic          r_irq_en;
  logic          r_overrun;
  state_t        r_state;
  logic [15:0]   r_bitcnt;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          r_parity;
`endif

  assign w_hit_tx      = (address == ADDR_TXDATA);
  assign w_hit_status  = (address == ADDR_STATUS);
  assign w_hit_ctrl    = (address == ADDR_CTRL);
  assign UartAddress   = w_hit_tx | w_hit_status | w_hit_ctrl;
  assign w_push        = MemWrite & w_hit_tx;
  assign w_ctrl_wr     = MemWrite & w_hit_ctrl;
  assign w_overrun_evt = w_push & w_full & ~w_pop;
  assign w_unused_data = &{1'b0, data[63:17]};

  assign w_busy        = (r_state != S_IDLE);
  assign w_bit_end     = (r_bitcnt == '0);
  assign w_reload      = (r_divisor == '0) ? '0 : r_divisor - 16'd1;
  assign w_pop         = ~w_empty & ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
  assign UartInterrupt = r_irq_en & w_empty & ~w_busy;
  assign tx            = r_tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata (data[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    rd_data = '0;
    if (MemRead) begin
      if (w_hit_status) begin
        rd_data[ST_COUNT_MSB:ST_COUNT_LSB] = 7'(w_count);
        rd_data[ST_OVERRUN_BIT]            = r_overrun;
        rd_data[ST_BUSY_BIT]               = w_busy;
        rd_data[ST_FULL_BIT]               = w_full;
        rd_data[ST_EMPTY_BIT]              = w_empty;
      end else if (w_hit_ctrl) begin
        rd_data[CTRL_DIV_MSB:CTRL_DIV_LSB] = r_divisor;
        rd_data[CTRL_IRQEN_BIT]            = r_irq_en;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_divisor <= 16'(DIV_RESET);
      r_irq_en  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_divisor <= data[15:0];
      r_irq_en  <= data[16];
      r_overrun <= 1'b0;
    end else if (w_overrun_evt) begin
      r_overrun <= 1'b1;
    end
  end

  // tx is registered from the current state, so the line lags the state by one cycle.
  always_comb begin
    unique case (r_state)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_shift[0];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_shift  <= w_head;
`ifdef MMIO_UART_TX_PARITY_EN
        r_parity <= even_parity(w_head);
`endif
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state  <= S_START;
            r_bitcnt <= w_reload;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_bitidx <= '0;
            r_bitcnt <= w_reload;
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bitcnt <= w_reload;
            if (r_bitidx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bitidx <= r_bitidx + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state  <= S_STOP;
            r_bitcnt <= w_reload;
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bitcnt <= w_reload;
            r_state  <= w_pop ? S_START : S_IDLE;
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx; frame length follows MMIO_UART_TX_PARITY_EN.
module tb_mmio_uart_tx;

  localparam logic [63:0] A_TX   = 64'h0000_0000_FFFF_0080;
  localparam logic [63:0] A_STAT = 64'h0000_0000_FFFF_0088;
  localparam logic [63:0] A_CTRL = 64'h0000_0000_FFFF_0090;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data = '0;
  logic [63:0] address = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [63:0] rd_data;
  logic        UartAddress;
  logic        UartInterrupt;
  logic        tx;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH (8),
    .DIV_RESET  (16)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .data          (data),
    .address       (address),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .rd_data       (rd_data),
    .UartAddress   (UartAddress),
    .UartInterrupt (UartInterrupt),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  // Frame cell idx: 0 start, 1..8 data LSB first, optional parity, then stop.
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef MMIO_UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic apply_reset();
    MemWrite = 1'b0; MemRead = 1'b0; address = '0; data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [63:0] a, input logic [63:0] v);
    address = a; data = v; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; address = '0; data = '0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] v, output logic hit);
    address = a; MemRead = 1'b1;
    #1;
    v = rd_data; hit = UartAddress;
    MemRead = 1'b0; address = '0;
  endtask

  task automatic test_reset();
    logic [63:0] v; logic h;
    MemWrite = 1'b0; MemRead = 1'b0; address = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (UartInterrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", UartInterrupt); end
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL reset_status: got %h expected 1", v); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_CTRL, v, h);
    checks++; if (v !== 64'h10) begin errors++; $display("FAIL reset_ctrl: got %h expected 10", v); end
  endtask

  task automatic test_decode();
    logic [63:0] v; logic h;
    rd(64'h0000_0000_FFFF_0098, v, h);
    checks++; if (h !== 1'b0 || v !== 64'h0) begin errors++; $display("FAIL decode_miss: got hit=%b data=%h expected hit=0 data=0", h, v); end
    rd(64'h0000_0001_FFFF_0088, v, h);
    checks++; if (h !== 1'b0 || v !== 64'h0) begin errors++; $display("FAIL decode_high: got hit=%b data=%h expected hit=0 data=0", h, v); end
    rd(A_TX, v, h);
    checks++; if (h !== 1'b1 || v !== 64'h0) begin errors++; $display("FAIL decode_tx: got hit=%b data=%h expected hit=1 data=0", h, v); end
    rd(A_STAT, v, h);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL decode_status: got hit=%b expected 1", h); end
  endtask

  task automatic test_single_frame();
    logic [63:0] v; logic h; logic e;
    apply_reset();
    wr(A_TX, 64'h55);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL sf_latency: got %b expected 1", tx); end
    for (int unsigned c = 0; c < FB*16; c++) begin
      @(negedge clk);
      e = exp_bit(8'h55, c / 16);
      checks++; if (tx !== e) begin errors++; $display("FAIL sf_bit cyc=%0d: got %b expected %b", c, tx, e); end
    end
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL sf_done_status: got %h expected 1", v); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v; logic h; logic e; logic ei;
    logic [7:0] bytes [3];
    int unsigned fc;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    fc = FB * 3;
    apply_reset();
    wr(A_CTRL, 64'h10003);
    rd(A_CTRL, v, h);
    checks++; if (v !== 64'h10003) begin errors++; $display("FAIL b2b_ctrl: got %h expected 10003", v); end
    checks++; if (UartInterrupt !== 1'b1) begin errors++; $display("FAIL b2b_irq_idle: got %b expected 1", UartInterrupt); end
    wr(A_TX, 64'h01);
    checks++; if (UartInterrupt !== 1'b0) begin errors++; $display("FAIL b2b_irq_push: got %b expected 0", UartInterrupt); end
    wr(A_TX, 64'h02);
    wr(A_TX, 64'h03);
    for (int unsigned c = 0; c < 3*fc; c++) begin
      e  = exp_bit(bytes[c / fc], (c % fc) / 3);
      ei = (c == 3*fc - 1);
      checks++; if (tx !== e) begin errors++; $display("FAIL b2b_bit cyc=%0d: got %b expected %b", c, tx, e); end
      checks++; if (UartInterrupt !== ei) begin errors++; $display("FAIL b2b_irq cyc=%0d: got %b expected %b", c, UartInterrupt, ei); end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] v; logic h;
    apply_reset();
    wr(A_CTRL, 64'h1);
    // The first byte moves to the shift register, so the tenth push is the one dropped.
    for (int unsigned i = 0; i < 10; i++) wr(A_TX, 64'hA0 + 64'(i));
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h80E) begin errors++; $display("FAIL ovr_status: got %h expected 80e", v); end
    wr(A_CTRL, 64'h1);
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h806) begin errors++; $display("FAIL ovr_clear: got %h expected 806", v); end
    repeat (120) @(negedge clk);
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL ovr_drain: got %h expected 1", v); end
  endtask

  task automatic test_full_pop_push();
    logic [63:0] v; logic h;
    apply_reset();
    wr(A_CTRL, 64'h4);
    for (int unsigned i = 0; i < 9; i++) wr(A_TX, 64'h10 + 64'(i));
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h806) begin errors++; $display("FAIL fpp_full: got %h expected 806", v); end
    repeat (4*FB - 8) @(negedge clk);
    wr(A_TX, 64'hEE);
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h806) begin errors++; $display("FAIL fpp_accept: got %h expected 806", v); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fpp_stop: got %b expected 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL fpp_next_start: got %b expected 0", tx); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] v; logic h;
    apply_reset();
    wr(A_TX, 64'h55);
    wr(A_TX, 64'h33);
    repeat (69) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rmf_bit3: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmf_tx_async: got %b expected 1", tx); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL rmf_status: got %h expected 1", v); end
    repeat (20) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmf_idle: got %b expected 1", tx); end
  endtask

  task automatic test_div_zero();
    logic [63:0] v; logic h; logic e;
    apply_reset();
    wr(A_CTRL, 64'h0);
    rd(A_CTRL, v, h);
    checks++; if (v !== 64'h0) begin errors++; $display("FAIL dz_ctrl: got %h expected 0", v); end
    wr(A_TX, 64'hA5);
    @(negedge clk);
    for (int unsigned c = 0; c < FB; c++) begin
      @(negedge clk);
      e = exp_bit(8'hA5, c);
      checks++; if (tx !== e) begin errors++; $display("FAIL dz_bit %0d: got %b expected %b", c, tx, e); end
    end
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL dz_status: got %h expected 1", v); end
  endtask

`ifdef MMIO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [63:0] v; logic h; logic e;
    apply_reset();
    wr(A_CTRL, 64'h2);
    wr(A_TX, 64'h07);
    @(negedge clk);
    for (int unsigned c = 0; c < 22; c++) begin
      @(negedge clk);
      e = exp_bit(8'h07, c / 2);
      checks++; if (tx !== e) begin errors++; $display("FAIL par_bit cyc=%0d: got %b expected %b", c, tx, e); end
      if (c == 18) begin
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL par_parity: got %b expected 1", tx); end
      end
    end
    rd(A_STAT, v, h);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL par_len: got %h expected 1", v); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_full_pop_push();
    test_reset_midframe();
    test_div_zero();
`ifdef MMIO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
